spi_puf_responder: RTL and testbench

SPI slave (mode 0, MSB first) that exposes the RO-PUF to an external SPI master. It decodes a command byte and accepts an 8-bit challenge, launching the PUF with a one-cycle start pulse. When the PUF finishes, it latches the 256-bit response and shifts it out on MISO as 32 bytes. It sits between the board-level SPI pins and `PUF_TOP`, and acts as the responder for the design's SPI master.

---
 rtl/spi_puf_responder.sv | 200 ++++++++++++++++++++
 tb/tb_spi_puf_responder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/spi_puf_responder.sv
// SPI mode-0 slave front end for the RO-PUF: command decode, challenge launch,
// status reporting and 32-byte response readout, all sampled on clk.
module spi_puf_responder #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sclk,
    input  logic         cs_n,
    input  logic         mosi,
    output logic         miso,
    output logic [7:0]   puf_challenge,
    output logic         puf_start,
    input  logic [255:0] puf_response,
    input  logic         puf_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_CHAL,
        S_STAT,
        S_RESP,
        S_DISCARD
    } state_t;

    state_t       state_q, state_d;
    logic [2:0]   sclk_sync_q, sclk_sync_d;
    logic [2:0]   cs_sync_q, cs_sync_d;
    logic [1:0]   mosi_sync_q, mosi_sync_d;
    logic [2:0]   bit_cnt_q, bit_cnt_d;
    logic [5:0]   byte_cnt_q, byte_cnt_d;
    logic [7:0]   rx_q, rx_d;
    logic [7:0]   tx_q, tx_d;
    logic         miso_q, miso_d;
    logic [7:0]   chal_q, chal_d;
    logic         start_q, start_d;
    logic         busy_q, busy_d;
    logic         valid_q, valid_d;
    logic         err_ovr_q, err_ovr_d;
    logic         err_cmd_q, err_cmd_d;
    logic [255:0] shadow_q, shadow_d;

    logic         sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [7:0]   rx_next;
    logic [7:0]   resp_idx;
    logic [7:0]   resp_byte;
    logic [7:0]   status_byte;

    // Index [0] is the first sync stage, [1] the synchronised value, [2] its previous value.
    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
    assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];

    assign resp_idx    = 8'd255 - {byte_cnt_q[4:0], 3'b000};
    assign resp_byte   = (valid_q && !byte_cnt_q[5]) ? shadow_q[resp_idx -: 8] : 8'h00;
    assign status_byte = {busy_q, valid_q, err_ovr_q, err_cmd_q, 4'b0000};

    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], sclk};
        cs_sync_d   = {cs_sync_q[1:0], cs_n};
        mosi_sync_d = {mosi_sync_q[0], mosi};
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        miso_d      = miso_q;
        chal_d      = chal_q;
        start_d     = 1'b0;
        busy_d      = busy_q;
        valid_d     = valid_q;
        err_ovr_d   = err_ovr_q;
        err_cmd_d   = err_cmd_q;
        shadow_d    = shadow_q;
        rx_next     = {rx_q[6:0], mosi_sync_q[1]};

        // Completion is applied first so a challenge finishing this cycle sees busy cleared.
        if (puf_done && busy_q) begin
            shadow_d = puf_response;
            valid_d  = 1'b1;
            busy_d   = 1'b0;
        end

        if (cs_rise) begin
            state_d    = S_IDLE;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            miso_d     = 1'b0;
        end else if (state_q == S_IDLE) begin
            miso_d = 1'b0;
            if (cs_fall) begin
                state_d    = S_CMD;
                bit_cnt_d  = '0;
                byte_cnt_d = '0;
                tx_d       = {SYNC_BYTE[6:0], 1'b0};
                miso_d     = SYNC_BYTE[7];
            end
        end else begin
            if (sclk_fall) begin
                miso_d = tx_q[7];
                tx_d   = {tx_q[6:0], 1'b0};
            end
            if (sclk_rise) begin
                rx_d      = rx_next;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    tx_d = 8'h00;
                    case (state_q)
                        S_CMD: begin
                            case (rx_next)
                                8'h01: state_d = S_CHAL;
                                8'h02: begin
                                    state_d = S_STAT;
                                    tx_d    = status_byte;
                                end
                                8'h03: begin
                                    state_d    = S_RESP;
                                    tx_d       = resp_byte;
                                    byte_cnt_d = 6'd1;
                                end
                                default: begin
                                    state_d   = S_DISCARD;
                                    err_cmd_d = 1'b1;
                                    tx_d      = 8'hEE;
                                end
                            endcase
                        end
                        S_CHAL: begin
                            state_d = S_DISCARD;
                            if (!busy_d) begin
                                chal_d  = rx_next;
                                start_d = 1'b1;
                                busy_d  = 1'b1;
                                valid_d = 1'b0;
                            end else begin
                                err_ovr_d = 1'b1;
                            end
                        end
                        S_STAT: begin
                            state_d   = S_DISCARD;
                            err_ovr_d = 1'b0;
                            err_cmd_d = 1'b0;
                        end
                        S_RESP: begin
                            tx_d = resp_byte;
                            if (!byte_cnt_q[5]) byte_cnt_d = byte_cnt_q + 6'd1;
                        end
                        default: tx_d = 8'h00;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sclk_sync_q <= '0;
            // Chip select history resets low so a cs_n already low cannot look like a fresh fall.
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            miso_q      <= 1'b0;
            chal_q      <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            err_ovr_q   <= 1'b0;
            err_cmd_q   <= 1'b0;
            shadow_q    <= '0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            chal_q      <= chal_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            err_ovr_q   <= err_ovr_d;
            err_cmd_q   <= err_cmd_d;
            shadow_q    <= shadow_d;
        end
    end

    assign miso          = miso_q;
    assign puf_challenge = chal_q;
    assign puf_start     = start_q;

endmodule

// File: tb/tb_spi_puf_responder.sv
// Directed bench for spi_puf_responder: an SPI master pushes expected MISO bytes
// into a queue, and a separate monitor reassembles MISO and compares.
module tb_spi_puf_responder;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         sclk = 1'b0;
    logic         cs_n = 1'b1;
    logic         mosi = 1'b0;
    logic         miso;
    logic [7:0]   puf_challenge;
    logic         puf_start;
    logic [255:0] puf_response = '0;
    logic         puf_done = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int start_cnt = 0;
    logic [7:0] exp_q[$];

    localparam logic [255:0] RESP_A = {4{64'h0123456789ABCDEF}};
    logic [7:0] resp_bytes[8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};

    spi_puf_responder #(.SYNC_BYTE(8'hA5)) dut (
        .clk          (clk),
        .reset        (reset),
        .sclk         (sclk),
        .cs_n         (cs_n),
        .mosi         (mosi),
        .miso         (miso),
        .puf_challenge(puf_challenge),
        .puf_start    (puf_start),
        .puf_response (puf_response),
        .puf_done     (puf_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Counts clk cycles with puf_start high, so one clean pulse adds exactly 1.
    always @(posedge clk) if (puf_start) start_cnt++;

    // Monitor: master samples MISO on SCLK rise; partial bytes are dropped at CS rise.
    initial begin
        int unsigned mon_bits;
        logic [7:0]  mon_sh;
        mon_bits = 0;
        mon_sh   = '0;
        forever begin
            @(posedge sclk or posedge cs_n);
            if (cs_n) begin
                mon_bits = 0;
            end else begin
                mon_sh = {mon_sh[6:0], miso};
                mon_bits++;
                if (mon_bits == 8) begin
                    mon_bits = 0;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL miso_unexpected: got 0x%0h, expected no byte", mon_sh);
                    end else begin
                        check("miso_byte", {24'h0, mon_sh}, {24'h0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    task automatic spi_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            #80 sclk = 1'b1;
            #80 sclk = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] b, input logic [7:0] e);
        exp_q.push_back(e);
        spi_bits(b, 8);
    endtask

    task automatic cs_begin();
        @(negedge clk);
        cs_n = 1'b0;
        #80;
    endtask

    task automatic cs_end();
        #80 cs_n = 1'b1;
        #200;
    endtask

    task automatic txn2(input logic [7:0] c, input logic [7:0] d,
                        input logic [7:0] e0, input logic [7:0] e1);
        cs_begin();
        spi_byte(c, e0);
        spi_byte(d, e1);
        cs_end();
    endtask

    task automatic pulse_done(input logic [255:0] r);
        @(negedge clk);
        puf_response = r;
        puf_done     = 1'b1;
        @(negedge clk);
        puf_done     = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_err + 1);
        $fatal(1);
    end

    initial begin
        int s0;
        repeat (4) @(posedge clk);
        #1;
        check("reset_miso", {31'h0, miso}, 32'h0);
        check("reset_start", {31'h0, puf_start}, 32'h0);
        check("reset_challenge", {24'h0, puf_challenge}, 32'h0);
        @(negedge clk) reset = 1'b0;
        repeat (4) @(negedge clk);

        txn2(8'h02, 8'h00, 8'hA5, 8'h00);

        // Bad command, then an aborted 3-bit byte, then status shows only err_cmd.
        txn2(8'h7F, 8'h00, 8'hA5, 8'hEE);
        cs_begin();
        spi_bits(8'h02, 3);
        cs_end();
        txn2(8'h02, 8'h00, 8'hA5, 8'h10);
        txn2(8'h02, 8'h00, 8'hA5, 8'h00);

        s0 = start_cnt;
        txn2(8'h01, 8'h5C, 8'hA5, 8'h00);
        check("start_pulse_5c", start_cnt - s0, 1);
        check("challenge_5c", {24'h0, puf_challenge}, 32'h5C);
        txn2(8'h02, 8'h00, 8'hA5, 8'h80);

        pulse_done(RESP_A);
        txn2(8'h02, 8'h00, 8'hA5, 8'h40);
        cs_begin();
        spi_byte(8'h03, 8'hA5);
        for (int k = 0; k < 32; k++) spi_byte(8'hFF, resp_bytes[k % 8]);
        spi_byte(8'hFF, 8'h00);
        cs_end();

        // Overrun: second challenge while the first is still running.
        s0 = start_cnt;
        txn2(8'h01, 8'h33, 8'hA5, 8'h00);
        check("start_pulse_33", start_cnt - s0, 1);
        s0 = start_cnt;
        txn2(8'h01, 8'h11, 8'hA5, 8'h00);
        check("start_pulse_busy", start_cnt - s0, 0);
        check("challenge_kept", {24'h0, puf_challenge}, 32'h33);
        txn2(8'h02, 8'h00, 8'hA5, 8'hA0);
        txn2(8'h02, 8'h00, 8'hA5, 8'h80);

        pulse_done(RESP_A);
        pulse_done('0);
        txn2(8'h02, 8'h00, 8'hA5, 8'h40);

        // Reset part-way through response byte 10; the shadow must still hold RESP_A up to then.
        cs_begin();
        spi_byte(8'h03, 8'hA5);
        for (int k = 0; k < 10; k++) spi_byte(8'hFF, resp_bytes[k % 8]);
        spi_bits(8'hFF, 4);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_miso", {31'h0, miso}, 32'h0);
        check("midreset_challenge", {24'h0, puf_challenge}, 32'h0);
        @(negedge clk) reset = 1'b0;
        repeat (8) @(negedge clk);
        check("no_resume_miso", {31'h0, miso}, 32'h0);
        cs_end();
        txn2(8'h02, 8'h00, 8'hA5, 8'h00);

        #200;
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
